// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch unit with a small in-order instruction queue. A
// three-state FSM (IDLE / REQ / FLUSH) keeps at most one instruction memory
// request outstanding. Fetched words are buffered together with their
// addresses, and the head entry is presented to the datapath with a
// valid/ready handshake. A redirect (branch/jump) flushes the queue and
// restarts fetching at the new address.
//
// Optional feature macro: FETCHQ_BYPASS_EN
//   When defined, a word acknowledged while the queue is empty is presented
//   combinationally on the datapath side in the same cycle. If the datapath
//   consumes it in that cycle, the word is never written into the queue.
//   When undefined, no combinational path exists from imem_* to inst_*, and
//   an acknowledged word appears one cycle after the ack.
//
// Parameters:
//   DEPTH     - number of queue entries (power of two, 2..16)
//   RESET_PC  - first fetch address after reset
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active low
//   redirect     in   flush queue and refetch from redirect_pc
//   redirect_pc  in   new fetch address (bits [1:0] ignored)
//   imem_req     out  instruction memory request
//   imem_addr    out  word-aligned fetch address
//   imem_ack     in   request accepted, imem_rdata valid this cycle
//   imem_rdata   in   fetched instruction word
//   inst_valid   out  head entry valid
//   inst_ready   in   datapath consumes head entry
//   instruction  out  head instruction word (zero when empty)
//   inst_pc      out  head instruction address (zero when empty)
//   pc_plus4     out  inst_pc + 4 (zero when empty)
//   count        out  number of queued entries
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    output logic [4:0]  count
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      fetch_pc;
    logic [31:0]      hold_addr;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [4:0]       count_q;
    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];

    logic ack_taken;
    logic fetch_ok;
    logic push;
    logic pop;
    logic queue_nonempty;
`ifdef FETCHQ_BYPASS_EN
    logic bypass;
`endif

    assign queue_nonempty = (count_q != 5'd0);
    assign ack_taken      = (state == REQ) && imem_ack;
    assign fetch_ok       = ack_taken && !redirect;

`ifdef FETCHQ_BYPASS_EN
    // An empty queue lets the acked word go straight to the datapath; it is
    // only stored if the datapath does not take it this cycle.
    assign bypass = fetch_ok && !queue_nonempty;
    assign push   = fetch_ok && !(bypass && inst_ready);
`else
    assign push   = fetch_ok;
`endif

    // Redirect discards any pop in the same cycle.
    assign pop = queue_nonempty && inst_ready && !redirect;

    assign imem_req  = (state != IDLE);
    // While flushing, the abandoned request keeps its original address until
    // the memory acknowledges it; fetch_pc already holds the new target.
    assign imem_addr = (state == FLUSH) ? hold_addr : fetch_pc;
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request is only launched when a slot is guaranteed: no push can occur
    // outside REQ, so count < DEPTH on entry means the eventual push fits.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (redirect || (count_q < DEPTH_C)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect && !imem_ack) begin
                    state_next = FLUSH;
                end else if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            hold_addr <= RESET_PC;
        end else begin
            if ((state == REQ) && redirect && !imem_ack) begin
                hold_addr <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (ack_taken) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= 5'd0;
        end else if (redirect) begin
            head    <= '0;
            tail    <= '0;
            count_q <= 5'd0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail] <= imem_rdata;
            pc_mem[tail]   <= fetch_pc;
        end
    end

    // Storage is never reset, so the head is masked to zero when empty.
    always_comb begin
        inst_valid  = queue_nonempty;
        instruction = queue_nonempty ? inst_mem[head] : 32'h0;
        inst_pc     = queue_nonempty ? pc_mem[head] : 32'h0;
`ifdef FETCHQ_BYPASS_EN
        if (bypass) begin
            inst_valid  = 1'b1;
            instruction = imem_rdata;
            inst_pc     = fetch_pc;
        end
`endif
        pc_plus4 = inst_valid ? (inst_pc + 32'd4) : 32'h0;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue (default build, DEPTH=4, RESET_PC=0).
// Acknowledged fetches are pushed to a scoreboard queue and compared against
// the head entry when the datapath consumes it. Instruction memory content is
// a fixed function of the address.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic [4:0]  count;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t sb[$];
    int     checks;
    int     passed;

    fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .instruction (instruction),
        .inst_pc     (inst_pc),
        .pc_plus4    (pc_plus4),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'h0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        inst_ready  = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        inst_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) $display("[TB] FAIL reset_imem_req: got %b want 0", imem_req); else passed++;
        checks++; if (imem_addr !== 32'h0) $display("[TB] FAIL reset_imem_addr: got %h want 0", imem_addr); else passed++;
        checks++; if (count !== 5'd0) $display("[TB] FAIL reset_count: got %0d want 0", count); else passed++;
        checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL reset_inst_valid: got %b want 0", inst_valid); else passed++;
        checks++; if (instruction !== 32'h0) $display("[TB] FAIL reset_instruction: got %h want 0", instruction); else passed++;
        checks++; if (inst_pc !== 32'h0) $display("[TB] FAIL reset_inst_pc: got %h want 0", inst_pc); else passed++;
        checks++; if (pc_plus4 !== 32'h0) $display("[TB] FAIL reset_pc_plus4: got %h want 0", pc_plus4); else passed++;
        rst = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("[TB] FAIL first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_stream();
        int          fetched  = 0;
        logic [31:0] exp_addr = 32'h0;
        entry_t      e;
        $display("[TB] test_stream");
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 24 && (fetched < 4 || sb.size() != 0); c++) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (inst_valid !== 1'b1 || instruction !== e.inst || inst_pc !== e.pc || pc_plus4 !== e.pc + 32'd4)
                    $display("[TB] FAIL stream_head: got v=%b inst=%h pc=%h pc4=%h want v=1 inst=%h pc=%h pc4=%h",
                             inst_valid, instruction, inst_pc, pc_plus4, e.inst, e.pc, e.pc + 32'd4);
                else passed++;
            end else begin
                checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL stream_empty_valid: got %b want 0", inst_valid); else passed++;
            end
            imem_ack = (fetched < 4);
            if (imem_req && imem_ack) begin
                checks++; if (imem_addr !== exp_addr) $display("[TB] FAIL stream_addr: got %h want %h", imem_addr, exp_addr); else passed++;
                sb.push_back('{inst: mem_word(exp_addr), pc: exp_addr});
                exp_addr += 32'd4;
                fetched++;
            end
            tick();
        end
        imem_ack = 1'b0;
        checks++; if (fetched != 4 || sb.size() != 0) $display("[TB] FAIL stream_done: got fetched=%0d left=%0d want 4 and 0", fetched, sb.size()); else passed++;
    endtask

    task automatic test_full_stall();
        int          accepted   = 0;
        bit          seen       = 1'b0;
        logic [31:0] first_addr = 32'h0;
        entry_t      e;
        $display("[TB] test_full_stall");
        do_reset();
        for (int c = 0; c < 30; c++) begin
            imem_ack = imem_req;
            if (imem_req) begin
                sb.push_back('{inst: mem_word(imem_addr), pc: imem_addr});
                accepted++;
            end
            tick();
        end
        imem_ack = 1'b0;
        checks++; if (accepted != 4) $display("[TB] FAIL full_accepts: got %0d want 4", accepted); else passed++;
        checks++; if (count !== 5'd4) $display("[TB] FAIL full_count: got %0d want 4", count); else passed++;
        checks++; if (imem_req !== 1'b0) $display("[TB] FAIL full_req: got %b want 0", imem_req); else passed++;
        inst_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (inst_valid !== 1'b1 || instruction !== e.inst || inst_pc !== e.pc)
                    $display("[TB] FAIL full_drain: got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h",
                             inst_valid, instruction, inst_pc, e.inst, e.pc);
                else passed++;
            end else begin
                checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL full_empty_valid: got %b want 0", inst_valid); else passed++;
            end
            if (imem_req && !seen) begin
                seen       = 1'b1;
                first_addr = imem_addr;
            end
            tick();
        end
        checks++; if (!seen || first_addr !== 32'h10) $display("[TB] FAIL full_resume_addr: got seen=%b addr=%h want addr=00000010", seen, first_addr); else passed++;
        checks++; if (count !== 5'd0) $display("[TB] FAIL full_drained_count: got %0d want 0", count); else passed++;
    endtask

    task automatic test_redirect_queue();
        int accepted = 0;
        bit reached  = 1'b0;
        bit seen     = 1'b0;
        $display("[TB] test_redirect_queue");
        do_reset();
        for (int c = 0; c < 30 && !reached; c++) begin
            if (count == 5'd3 && imem_req) begin
                reached = 1'b1;
            end else begin
                imem_ack = imem_req && (accepted < 3);
                if (imem_ack) accepted++;
                tick();
            end
        end
        checks++; if (!reached) $display("[TB] FAIL redir_fill: got count=%0d want 3 with request pending", count); else passed++;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        imem_ack    = 1'b1;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b0;
        checks++; if (count !== 5'd0 || inst_valid !== 1'b0) $display("[TB] FAIL redir_clear: got count=%0d v=%b want 0 0", count, inst_valid); else passed++;
        checks++; if (instruction !== 32'h0 || inst_pc !== 32'h0) $display("[TB] FAIL redir_zero_head: got inst=%h pc=%h want 0 0", instruction, inst_pc); else passed++;
        for (int c = 0; c < 5 && !seen; c++) begin
            if (imem_req) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen || imem_addr !== 32'h100) $display("[TB] FAIL redir_addr: got seen=%b addr=%h want 00000100", seen, imem_addr); else passed++;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (count !== 5'd1 || inst_pc !== 32'h100 || instruction !== mem_word(32'h100))
            $display("[TB] FAIL redir_refetch: got count=%0d pc=%h inst=%h want 1 00000100 %h", count, inst_pc, instruction, mem_word(32'h100));
        else passed++;
    endtask

    task automatic test_redirect_flush();
        bit seen = 1'b0;
        $display("[TB] test_redirect_flush");
        do_reset();
        for (int c = 0; c < 5 && !seen; c++) begin
            if (imem_req) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen || imem_addr !== 32'h0) $display("[TB] FAIL flush_first_req: got seen=%b addr=%h want 0", seen, imem_addr); else passed++;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("[TB] FAIL flush_hold0: got req=%b addr=%h want 1 0", imem_req, imem_addr); else passed++;
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("[TB] FAIL flush_hold: got req=%b addr=%h want 1 0", imem_req, imem_addr); else passed++;
            tick();
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++; if (count !== 5'd0 || inst_valid !== 1'b0) $display("[TB] FAIL flush_drop: got count=%0d v=%b want 0 0", count, inst_valid); else passed++;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            if (imem_req) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen || imem_addr !== 32'h300) $display("[TB] FAIL flush_new_addr: got seen=%b addr=%h want 00000300", seen, imem_addr); else passed++;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (count !== 5'd1 || inst_pc !== 32'h300 || instruction !== mem_word(32'h300))
            $display("[TB] FAIL flush_refetch: got count=%0d pc=%h inst=%h want 1 00000300 %h", count, inst_pc, instruction, mem_word(32'h300));
        else passed++;
    endtask

    task automatic test_wrap();
        bit seen = 1'b0;
        $display("[TB] test_wrap");
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            if (imem_req) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen || imem_addr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_req_addr: got seen=%b addr=%h want fffffffc", seen, imem_addr); else passed++;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || instruction !== mem_word(32'hFFFF_FFFC))
            $display("[TB] FAIL wrap_head: got v=%b pc=%h pc4=%h inst=%h want 1 fffffffc 00000000 %h",
                     inst_valid, inst_pc, pc_plus4, instruction, mem_word(32'hFFFF_FFFC));
        else passed++;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            if (imem_req) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen || imem_addr !== 32'h0) $display("[TB] FAIL wrap_next_addr: got seen=%b addr=%h want 0", seen, imem_addr); else passed++;
    endtask

    task automatic test_async_reset();
        int accepted = 0;
        bit reached  = 1'b0;
        $display("[TB] test_async_reset");
        do_reset();
        for (int c = 0; c < 30 && !reached; c++) begin
            if (count == 5'd2 && imem_req) begin
                reached = 1'b1;
            end else begin
                imem_ack = imem_req && (accepted < 2);
                if (imem_ack) accepted++;
                tick();
            end
        end
        imem_ack = 1'b0;
        checks++; if (!reached) $display("[TB] FAIL arst_fill: got count=%0d want 2 with request pending", count); else passed++;
        #1 rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) $display("[TB] FAIL arst_imem: got req=%b addr=%h want 0 0", imem_req, imem_addr); else passed++;
        checks++; if (count !== 5'd0 || inst_valid !== 1'b0) $display("[TB] FAIL arst_queue: got count=%0d v=%b want 0 0", count, inst_valid); else passed++;
        checks++;
        if (instruction !== 32'h0 || inst_pc !== 32'h0 || pc_plus4 !== 32'h0)
            $display("[TB] FAIL arst_head: got inst=%h pc=%h pc4=%h want 0 0 0", instruction, inst_pc, pc_plus4);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || count !== 5'd0) $display("[TB] FAIL arst_restart: got req=%b addr=%h count=%0d want 1 0 0", imem_req, imem_addr, count); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_stream();
        test_full_stall();
        test_redirect_queue();
        test_redirect_flush();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
